// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, DATA_WIDTH data bits LSB-first, optional
// even/odd parity bit, one stop bit. Bit period set by Prescale (0 treated as 1).
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [7:0]            Prescale,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic [7:0]            r_prescale;
    logic [7:0]            r_edge_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_tx_out;
    logic                  r_busy;

    logic                  w_bit_end;
    logic                  w_parity;
    logic [IDX_W-1:0]      w_idx_next;

    assign w_bit_end  = (r_edge_cnt == (r_prescale - 8'd1));
    assign w_parity   = (^r_data) ^ r_par_typ;
    assign w_idx_next = r_idx + IDX_W'(1);

    assign TX_OUT = r_tx_out;
    assign Busy   = r_busy;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= IDLE;
            r_data     <= '0;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_prescale <= 8'd0;
            r_edge_cnt <= 8'd0;
            r_idx      <= '0;
            r_tx_out   <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx_out   <= 1'b1;
                    r_busy     <= 1'b0;
                    r_edge_cnt <= 8'd0;
                    r_idx      <= '0;
                    if (Data_Valid) begin
                        // Shadows freeze every frame parameter until the stop bit ends.
                        r_data     <= P_DATA;
                        r_par_en   <= PAR_EN;
                        r_par_typ  <= PAR_TYP;
                        r_prescale <= (Prescale == 8'd0) ? 8'd1 : Prescale;
                        r_tx_out   <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= START;
                    end
                end

                START: begin
                    if (w_bit_end) begin
                        r_edge_cnt <= 8'd0;
                        r_idx      <= '0;
                        r_tx_out   <= r_data[0];
                        r_state    <= DATA;
                    end else begin
                        r_edge_cnt <= r_edge_cnt + 8'd1;
                    end
                end

                DATA: begin
                    if (w_bit_end) begin
                        r_edge_cnt <= 8'd0;
                        if (r_idx == LAST_IDX) begin
                            if (r_par_en) begin
                                r_tx_out <= w_parity;
                                r_state  <= PARITY;
                            end else begin
                                r_tx_out <= 1'b1;
                                r_state  <= STOP;
                            end
                        end else begin
                            r_idx    <= w_idx_next;
                            r_tx_out <= r_data[w_idx_next];
                        end
                    end else begin
                        r_edge_cnt <= r_edge_cnt + 8'd1;
                    end
                end

                PARITY: begin
                    if (w_bit_end) begin
                        r_edge_cnt <= 8'd0;
                        r_tx_out   <= 1'b1;
                        r_state    <= STOP;
                    end else begin
                        r_edge_cnt <= r_edge_cnt + 8'd1;
                    end
                end

                STOP: begin
                    if (w_bit_end) begin
                        // Busy drops here; the next accept needs one more edge in IDLE.
                        r_edge_cnt <= 8'd0;
                        r_tx_out   <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= IDLE;
                    end else begin
                        r_edge_cnt <= r_edge_cnt + 8'd1;
                    end
                end

                default: begin
                    r_state  <= IDLE;
                    r_tx_out <= 1'b1;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: each frame's serial pattern is a
// hand-computed constant, checked every cycle along with Busy.
module tb_uart_tx_serializer;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] Prescale;
    logic       TX_OUT;
    logic       Busy;

    int checks   = 0;
    int failures = 0;

    uart_tx_serializer #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge. exp_bits[k] is the k-th serial bit on the line.
    task automatic send_frame(input string tag, input logic [7:0] data, input logic [7:0] pre,
                              input int p, input logic pe, input logic pt,
                              input logic [10:0] exp_bits, input bit hold,
                              input bit disturb, input logic [7:0] next_data);
        int nbits;
        int len;
        int bad;
        nbits      = pe ? 11 : 10;
        len        = nbits * p;
        bad        = failures;
        P_DATA     = data;
        Prescale   = pre;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Data_Valid = 1'b1;
        for (int k = 0; k < len; k++) begin
            @(negedge CLK);
            check({tag, " tx"}, {31'd0, TX_OUT}, {31'd0, exp_bits[k / p]});
            check({tag, " busy"}, {31'd0, Busy}, 32'd1);
            if (k == 0 && !hold) Data_Valid = 1'b0;
            if (hold && k == 3) P_DATA = next_data;
            if (disturb && k == 20) begin
                Data_Valid = 1'b1;
                P_DATA     = 8'hFF;
                Prescale   = 8'd3;
                PAR_EN     = 1'b1;
                PAR_TYP    = 1'b1;
            end
            if (disturb && k == 21) Data_Valid = 1'b0;
        end
        @(negedge CLK);
        check({tag, " idle tx"}, {31'd0, TX_OUT}, 32'd1);
        check({tag, " idle busy"}, {31'd0, Busy}, 32'd0);
        $display("frame %s data=%02h P=%0d par_en=%0d errors=%0d", tag, data, p, pe, failures - bad);
    endtask

    initial begin
        RST        = 1'b0;
        P_DATA     = 8'h00;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        Prescale   = 8'd8;

        repeat (3) @(negedge CLK);
        check("reset tx", {31'd0, TX_OUT}, 32'd1);
        check("reset busy", {31'd0, Busy}, 32'd0);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        check("post-reset tx", {31'd0, TX_OUT}, 32'd1);
        check("post-reset busy", {31'd0, Busy}, 32'd0);

        send_frame("a5_p8", 8'hA5, 8'd8, 8, 1'b0, 1'b0, 11'b00_1101001010, 1'b0, 1'b0, 8'h00);
        send_frame("03_even", 8'h03, 8'd4, 4, 1'b1, 1'b0, 11'b10000000110, 1'b0, 1'b0, 8'h00);
        send_frame("03_odd", 8'h03, 8'd4, 4, 1'b1, 1'b1, 11'b11000000110, 1'b0, 1'b0, 8'h00);

        send_frame("5a_disturb", 8'h5A, 8'd4, 4, 1'b0, 1'b0, 11'b00_1010110100, 1'b0, 1'b1, 8'h00);
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            check("no 2nd frame busy", {31'd0, Busy}, 32'd0);
            check("no 2nd frame tx", {31'd0, TX_OUT}, 32'd1);
        end

        send_frame("81_b2b", 8'h81, 8'd2, 2, 1'b0, 1'b0, 11'b00_1100000010, 1'b1, 1'b0, 8'h7E);
        send_frame("7e_b2b", 8'h7E, 8'd2, 2, 1'b0, 1'b0, 11'b00_1011111100, 1'b0, 1'b0, 8'h00);

        // Abort a frame during data bit 3 (cycles 16..19 at P=4).
        P_DATA     = 8'hC3;
        Prescale   = 8'd4;
        PAR_EN     = 1'b0;
        Data_Valid = 1'b1;
        for (int k = 0; k < 18; k++) begin
            @(negedge CLK);
            if (k == 0) Data_Valid = 1'b0;
        end
        check("pre-abort tx", {31'd0, TX_OUT}, 32'd0);
        check("pre-abort busy", {31'd0, Busy}, 32'd1);
        #2 RST = 1'b0;
        #1;
        check("async reset tx", {31'd0, TX_OUT}, 32'd1);
        check("async reset busy", {31'd0, Busy}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("after abort busy", {31'd0, Busy}, 32'd0);
        send_frame("c3_fresh", 8'hC3, 8'd4, 4, 1'b0, 1'b0, 11'b00_1110000110, 1'b0, 1'b0, 8'h00);

        send_frame("55_p0", 8'h55, 8'd0, 1, 1'b0, 1'b0, 11'b00_1010101010, 1'b0, 1'b0, 8'h00);
        send_frame("55_p1", 8'h55, 8'd1, 1, 1'b0, 1'b0, 11'b00_1010101010, 1'b0, 1'b0, 8'h00);

        repeat (2) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

UART transmit engine for the UART peripheral: accepts one parallel byte per handshake and drives it onto the serial line. The frame is start bit, 8 data bits LSB-first, an optional even/odd parity bit, and one stop bit. The block sits between the peripheral's TX register/FIFO and the TX pin. It uses the same `Prescale` register the receive side uses as its per-bit clock-edge count, so both directions run at one baud setting.

## Interface
- `DATA_WIDTH`, 8, payload bits per frame.
- `CLK` input 1: system clock, all state updates on rising edge.
- `RST` input 1: asynchronous, active-low reset.
- `P_DATA` input DATA_WIDTH: byte to transmit, sampled on the accepting edge.
- `Data_Valid` input 1: request to send `P_DATA`. Honoured only while `Busy`=0.
- `PAR_EN` input 1: 1 inserts a parity bit after the data bits.
- `PAR_TYP` input 1: 0 = even parity, 1 = odd parity.
- `Prescale` input 8: clock cycles per serial bit. Value 0 is treated as 1.
- `TX_OUT` output 1: serial line, registered, idle-high.
- `Busy` output 1: registered, high while a frame is in flight.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Shadow registers (data, `PAR_EN`, `PAR_TYP`, effective prescale) load on the accepting edge. They stay frozen for the whole frame, so input changes mid-frame have no effect.
- 8-bit bit-period counter `Edge_Cnt` runs 0..P-1, where P is the effective prescale. The bit ends when `Edge_Cnt`=P-1; the counter then wraps to 0.
- 3-bit (log2 DATA_WIDTH) data index counts 0..DATA_WIDTH-1.
- IDLE: `TX_OUT`=1, `Busy`=0. On `Data_Valid`=1, load the shadows and move to START. On that same edge, `TX_OUT`←0 and `Busy`←1.
- START: `TX_OUT`=0 for P cycles, then DATA with index 0.
- DATA: `TX_OUT`=shadow[index] for P cycles per bit.
  - After bit DATA_WIDTH-1, go to PARITY if shadow `PAR_EN`=1, else STOP.
- PARITY: `TX_OUT` = XOR-reduce(shadow data) XOR shadow `PAR_TYP`, held for P cycles. Then STOP.
- STOP: `TX_OUT`=1 for P cycles.
  - At the end of the stop bit, go to IDLE and `Busy`←0. `TX_OUT` stays 1.
- `Data_Valid` while `Busy`=1 is ignored: no queueing, no error flag. The upstream block holds `Data_Valid` until it sees `Busy`=0.
- Parity is computed from the latched shadow data, never from live `P_DATA`.

## Timing
- Reset values: `TX_OUT`=1, `Busy`=0, state IDLE, counters 0, shadows 0.
- Reset asserted mid-frame: `TX_OUT` goes 1 and `Busy` goes 0 immediately (asynchronous). The partial frame is abandoned.
- Latency: the start bit is visible on `TX_OUT` in the cycle immediately after the accepting edge.
- Frame length = (10 + `PAR_EN`) × P cycles of `Busy`=1.
- Back-to-back: `Busy` falls on the edge that ends the stop bit. The earliest next accept is the following edge, so there is a minimum of one idle-high cycle between frames.
- `Data_Valid` high on the same edge `Busy` falls is not accepted. Acceptance requires state IDLE at that edge.
- P=1: every bit lasts one cycle. `Edge_Cnt` stays 0.
- `TX_OUT` is glitch-free: driven only from a flop.

## Test plan
- 0xA5, P=8, `PAR_EN`=0 -> `TX_OUT` = 0,1,0,1,0,0,1,0,1,1, each held exactly 8 cycles. `Busy` high for 80 cycles, then `TX_OUT`=1 and `Busy`=0.
- 0x03, P=4, `PAR_EN`=1, `PAR_TYP`=0 -> parity bit 0 after the data bits, stop bit follows, `Busy` high 44 cycles. Repeat with `PAR_TYP`=1 -> parity bit 1.
- During a 0x5A frame, pulse `Data_Valid` with `P_DATA`=0xFF and change `Prescale` and `PAR_EN` -> the 0x5A frame is unchanged and no second frame starts.
- `Data_Valid` held high continuously with 0x81 then 0x7E, P=2 -> two complete frames separated by exactly one idle-high cycle.
- Assert `RST` low in the middle of data bit 3 -> `TX_OUT`=1 and `Busy`=0 asynchronously. After release, a fresh 0xC3 frame transmits correctly.
- `Prescale`=0 and `Prescale`=1 with 0x55 -> bits last 1 cycle each, 10-cycle frame, pattern 0,1,0,1,0,1,0,1,0,1.
